bel_fft_avl_mif_arb: RTL and testbench

Parametrised Avalon-MM master interface for the bel_fft core. It arbitrates NUM_PORTS internal memory clients onto one Avalon port using round-robin arbitration. It supports up to MAX_PEND pipelined (outstanding) reads, and routes each read response back to its issuing client through an in-order tag FIFO. It sits between the FFT datapath/address generators and the system interconnect, and replaces the fixed 4-port, single-outstanding-read interface.

---
 rtl/bel_fft_mif_pkg.sv | 30 +++
 rtl/bel_fft_tag_fifo.sv | 69 ++++++
 rtl/bel_fft_avl_mif_arb.sv | 144 ++++++++++++++
 tb/tb_bel_fft_avl_mif_arb.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bel_fft_mif_pkg.sv
// rtl/bel_fft_mif_pkg.sv - shared helpers for the bel_fft Avalon master interface
//
// Purpose: width helpers and flattened-vector slicing used by the arbiter
// and its tag FIFO. No ports.
package bel_fft_mif_pkg;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

  // Tag width for a given port count (at least one bit).
  function automatic int tag_w(input int num_ports);
    return (clog2(num_ports) < 1) ? 1 : clog2(num_ports);
  endfunction

  // Occupancy counter width for a FIFO of the given depth (holds 0..depth).
  function automatic int cnt_w(input int max_pend);
    return clog2(max_pend) + 1;
  endfunction

  // Low bit of slice idx in a flattened vector of width-bit fields.
  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/bel_fft_tag_fifo.sv
// rtl/bel_fft_tag_fifo.sv - in-order tag FIFO for outstanding reads
//
// Purpose: holds the issuing port number of each outstanding read so the
// response can be routed back in issue order.
// Ports:
//   clk_i  clock
//   clr    synchronous clear (empties the FIFO)
//   push   write wdata (accepted when not full, or when popping this cycle)
//   wdata  tag to store
//   pop    discard head entry (ignored when empty)
//   rdata  head entry (valid while not empty)
//   full   DEPTH entries stored
//   empty  no entries stored
module bel_fft_tag_fifo
  import bel_fft_mif_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A pop frees the head slot in the same cycle, so a full FIFO can still push.
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk_i) begin
    if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bel_fft_avl_mif_arb.sv
// rtl/bel_fft_avl_mif_arb.sv - round-robin Avalon-MM master with pipelined reads
//
// Purpose: arbitrates NUM_PORTS memory clients onto one Avalon port, keeps up
// to MAX_PEND reads outstanding and routes responses back by tag.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   address/writedata/read/write Avalon command, driven from the grant
//   waitrequest                  Avalon stall
//   readdata/readdatavalid       Avalon read response {re, im}
//   adr_i/dat_re_i/dat_im_i      flattened per-port address and write data
//   rd_i/wr_i                    per-port read/write requests
//   dat_re_o/dat_im_o            registered read data shared by all ports
//   ack_o                        per-port completion pulse
//   err_o                        per-port rd+wr conflict pulse
//   proto_err_o                  sticky: response with nothing outstanding
module bel_fft_avl_mif_arb
  import bel_fft_mif_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int WORD_WIDTH = 16,
  parameter int MIF_AWIDTH = 32,
  parameter int MAX_PEND   = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  output logic [MIF_AWIDTH-1:0]           address,
  input  logic [2*WORD_WIDTH-1:0]         readdata,
  output logic [2*WORD_WIDTH-1:0]         writedata,
  output logic                            read,
  output logic                            write,
  input  logic                            waitrequest,
  input  logic                            readdatavalid,
  input  logic [NUM_PORTS*MIF_AWIDTH-1:0] adr_i,
  input  logic [NUM_PORTS*WORD_WIDTH-1:0] dat_re_i,
  input  logic [NUM_PORTS*WORD_WIDTH-1:0] dat_im_i,
  input  logic [NUM_PORTS-1:0]            rd_i,
  input  logic [NUM_PORTS-1:0]            wr_i,
  output logic [WORD_WIDTH-1:0]           dat_re_o,
  output logic [WORD_WIDTH-1:0]           dat_im_o,
  output logic [NUM_PORTS-1:0]            ack_o,
  output logic [NUM_PORTS-1:0]            err_o,
  output logic                            proto_err_o
);

  localparam int TAG_W = tag_w(NUM_PORTS);
  localparam int DW    = 2 * WORD_WIDTH;
  localparam logic [TAG_W-1:0] LAST_PORT = TAG_W'(NUM_PORTS - 1);

  logic [TAG_W-1:0]     ptr_q, grant_q, arb_grant, grant, fifo_head;
  logic                 locked_q, lock_rd_q;
  logic [NUM_PORTS-1:0] pending_q, rd_ack_q, elig_wr, elig_rd, wr_ack, rd_issue;
  logic                 arb_found, arb_rd, cmd_valid, cmd_rd, accept;
  logic                 fifo_full, fifo_empty, rsp_valid;

  // Only the registered read ack can coincide with a read-eligible port: a
  // write ack always belongs to a port with wr_i high, which is never read-eligible.
  assign elig_wr = wr_i & ~rd_i;
  assign elig_rd = rd_i & ~wr_i & ~pending_q & ~rd_ack_q & {NUM_PORTS{~fifo_full}};

  always_comb begin
    int idx;
    idx       = 0;
    arb_found = 1'b0;
    arb_grant = ptr_q;
    arb_rd    = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (!arb_found && (elig_wr[idx] || elig_rd[idx])) begin
        arb_found = 1'b1;
        arb_grant = TAG_W'(idx);
        arb_rd    = elig_rd[idx];
      end
    end
  end

  // A stalled command keeps its grant and direction until Avalon accepts it.
  assign grant     = locked_q ? grant_q : arb_grant;
  assign cmd_valid = locked_q | arb_found;
  assign cmd_rd    = locked_q ? lock_rd_q : arb_rd;
  assign read      = cmd_valid & cmd_rd;
  assign write     = cmd_valid & ~cmd_rd;
  assign accept    = cmd_valid & ~waitrequest;
  assign address   = adr_i[slice_lo(int'(grant), MIF_AWIDTH) +: MIF_AWIDTH];
  assign writedata = {dat_re_i[slice_lo(int'(grant), WORD_WIDTH) +: WORD_WIDTH],
                      dat_im_i[slice_lo(int'(grant), WORD_WIDTH) +: WORD_WIDTH]};
  assign rsp_valid = readdatavalid & ~fifo_empty;

  always_comb begin
    wr_ack   = '0;
    rd_issue = '0;
    if (accept && !cmd_rd) wr_ack[grant]   = 1'b1;
    if (accept && cmd_rd)  rd_issue[grant] = 1'b1;
  end

  assign ack_o = wr_ack | rd_ack_q;
  assign err_o = rd_i & wr_i;

  bel_fft_tag_fifo #(
    .WIDTH (TAG_W),
    .DEPTH (MAX_PEND)
  ) u_tag_fifo (
    .clk_i (clk_i),
    .clr   (rst_i),
    .push  (accept & cmd_rd),
    .wdata (grant),
    .pop   (rsp_valid),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q       <= '0;
      grant_q     <= '0;
      locked_q    <= 1'b0;
      lock_rd_q   <= 1'b0;
      pending_q   <= '0;
      rd_ack_q    <= '0;
      dat_re_o    <= '0;
      dat_im_o    <= '0;
      proto_err_o <= 1'b0;
    end else begin
      if (cmd_valid) begin
        locked_q  <= waitrequest;
        grant_q   <= grant;
        lock_rd_q <= cmd_rd;
      end
      if (accept) ptr_q <= (grant == LAST_PORT) ? '0 : grant + 1'b1;
      // pending clears at the end of the ack cycle; a port in its ack cycle
      // cannot be issuing, so set and clear never collide on one bit.
      pending_q <= (pending_q & ~rd_ack_q) | rd_issue;
      rd_ack_q  <= '0;
      if (rsp_valid) begin
        dat_re_o           <= readdata[DW-1 -: WORD_WIDTH];
        dat_im_o           <= readdata[WORD_WIDTH-1:0];
        rd_ack_q[fifo_head] <= 1'b1;
      end
      if (readdatavalid && fifo_empty) proto_err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bel_fft_avl_mif_arb.sv
// tb/tb_bel_fft_avl_mif_arb.sv - scoreboard bench for bel_fft_avl_mif_arb
module tb_bel_fft_avl_mif_arb;

  localparam int NP = 4;
  localparam int WW = 16;
  localparam int AW = 32;
  localparam int MP = 2;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [AW-1:0]     address;
  logic [2*WW-1:0]   readdata;
  logic [2*WW-1:0]   writedata;
  logic              read, write, waitrequest, readdatavalid;
  logic [NP*AW-1:0]  adr_i;
  logic [NP*WW-1:0]  dat_re_i, dat_im_i;
  logic [NP-1:0]     rd_i, wr_i;
  logic [WW-1:0]     dat_re_o, dat_im_o;
  logic [NP-1:0]     ack_o, err_o;
  logic              proto_err_o;

  bel_fft_avl_mif_arb #(
    .NUM_PORTS(NP), .WORD_WIDTH(WW), .MIF_AWIDTH(AW), .MAX_PEND(MP)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .address(address), .readdata(readdata),
    .writedata(writedata), .read(read), .write(write), .waitrequest(waitrequest),
    .readdatavalid(readdatavalid), .adr_i(adr_i), .dat_re_i(dat_re_i),
    .dat_im_i(dat_im_i), .rd_i(rd_i), .wr_i(wr_i), .dat_re_o(dat_re_o),
    .dat_im_o(dat_im_o), .ack_o(ack_o), .err_o(err_o), .proto_err_o(proto_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic            wr;
    logic [AW-1:0]   addr;
    logic [2*WW-1:0] data;
  } cmd_t;

  typedef struct packed {
    logic [NP-1:0]   mask;
    logic            rd;
    logic [2*WW-1:0] data;
  } ack_t;

  cmd_t cmd_q[$];
  ack_t ack_q[$];
  int checks = 0;
  int errors = 0;
  logic [NP-1:0] ack_seen = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted command and every ack is matched against the queues.
  always @(negedge clk_i) begin
    cmd_t c;
    ack_t a;
    ack_seen <= ack_o;
    if (!rst_i) begin
      if ((read || write) && !waitrequest) begin
        if (cmd_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_cmd actual=addr %0h wr %0b required=no command", address, write);
        end else begin
          c = cmd_q.pop_front();
          chk("cmd_kind_wr", 64'(write), 64'(c.wr));
          chk("cmd_addr", 64'(address), 64'(c.addr));
          if (c.wr) chk("cmd_wdata", 64'(writedata), 64'(c.data));
        end
      end
      if (ack_o != '0) begin
        if (ack_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack actual=%0h required=none", ack_o);
        end else begin
          a = ack_q.pop_front();
          chk("ack_mask", 64'(ack_o), 64'(a.mask));
          if (a.rd) chk("rd_data", 64'({dat_re_o, dat_im_o}), 64'(a.data));
        end
      end
    end
  end

  // Clients drop a request after the cycle in which they saw their ack.
  task automatic tick();
    @(posedge clk_i);
    #1;
    rd_i = rd_i & ~ack_seen;
    wr_i = wr_i & ~ack_seen;
  endtask

  task automatic set_port(input int p, input logic [AW-1:0] a,
                          input logic [WW-1:0] re, input logic [WW-1:0] im);
    adr_i[p*AW +: AW]    = a;
    dat_re_i[p*WW +: WW] = re;
    dat_im_i[p*WW +: WW] = im;
  endtask

  task automatic exp_wr(input int p, input logic [AW-1:0] a,
                        input logic [WW-1:0] re, input logic [WW-1:0] im);
    set_port(p, a, re, im);
    cmd_q.push_back(cmd_t'{wr: 1'b1, addr: a, data: {re, im}});
    ack_q.push_back(ack_t'{mask: NP'(1) << p, rd: 1'b0, data: '0});
  endtask

  task automatic exp_rd_cmd(input int p, input logic [AW-1:0] a);
    set_port(p, a, '0, '0);
    cmd_q.push_back(cmd_t'{wr: 1'b0, addr: a, data: '0});
  endtask

  task automatic exp_rd_ack(input int p, input logic [2*WW-1:0] d);
    ack_q.push_back(ack_t'{mask: NP'(1) << p, rd: 1'b1, data: d});
  endtask

  initial begin
    rst_i = 1'b1; rd_i = '0; wr_i = '0; adr_i = '0; dat_re_i = '0; dat_im_i = '0;
    readdata = '0; waitrequest = 1'b0; readdatavalid = 1'b0;
    tick(); tick();
    rst_i = 1'b0;
    #2;
    chk("rst_read", 64'(read), 64'd0);
    chk("rst_write", 64'(write), 64'd0);
    chk("rst_ack", 64'(ack_o), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    chk("rst_proto_err", 64'(proto_err_o), 64'd0);
    chk("rst_dat_re", 64'(dat_re_o), 64'd0);
    chk("rst_dat_im", 64'(dat_im_o), 64'd0);

    // All four ports write at once: grants 0,1,2,3.
    for (int p = 0; p < NP; p++)
      exp_wr(p, 32'h100 + 32'(p) * 4, 16'hA000 + 16'(p), 16'h5000 + 16'(p));
    wr_i = 4'b1111;
    repeat (4) tick();
    // Two rounds of ports 1 and 3 only: grants 1,3,1,3.
    for (int r = 0; r < 2; r++) begin
      exp_wr(1, 32'h200 + 32'(r) * 16, 16'hB100 + 16'(r), 16'hC100);
      exp_wr(3, 32'h208 + 32'(r) * 16, 16'hB300 + 16'(r), 16'hC300);
      wr_i = 4'b1010;
      tick(); tick();
    end

    // Single write, port 2: command and ack in the same cycle.
    exp_wr(2, 32'h10, 16'h1111, 16'h2222);
    wr_i = 4'b0100;
    #2;
    chk("wr2_write", 64'(write), 64'd1);
    chk("wr2_address", 64'(address), 64'h10);
    chk("wr2_ack", 64'(ack_o), 64'b0100);
    tick(); tick();

    // Single read, port 1: response 3 cycles after accept, ack one cycle later.
    exp_rd_cmd(1, 32'h20);
    exp_rd_ack(1, 32'h1234ABCD);
    rd_i = 4'b0010;
    tick(); tick(); tick();
    readdatavalid = 1'b1; readdata = 32'h1234ABCD;
    tick();
    readdatavalid = 1'b0; readdata = '0;
    #2;
    chk("rd1_ack", 64'(ack_o), 64'b0010);
    chk("rd1_dat_re", 64'(dat_re_o), 64'h1234);
    chk("rd1_dat_im", 64'(dat_im_o), 64'hABCD);
    tick(); tick();

    // Port 0 write stalled 5 cycles while port 3 waits.
    exp_wr(0, 32'h300, 16'h3000, 16'h3001);
    exp_wr(3, 32'h330, 16'h3300, 16'h3301);
    waitrequest = 1'b1;
    wr_i = 4'b0001;
    #2;
    chk("stall_write", 64'(write), 64'd1);
    chk("stall_addr", 64'(address), 64'h300);
    tick();
    wr_i = wr_i | 4'b1000;
    for (int i = 0; i < 4; i++) begin
      #2;
      chk("stall_write", 64'(write), 64'd1);
      chk("stall_addr", 64'(address), 64'h300);
      tick();
    end
    waitrequest = 1'b0;
    tick(); tick(); tick();

    // Reads from ports 0,1,2 with only two outstanding allowed.
    exp_rd_cmd(0, 32'h400);
    exp_rd_cmd(1, 32'h410);
    exp_rd_cmd(2, 32'h420);
    exp_rd_ack(0, 32'h0001F000);
    exp_rd_ack(1, 32'h0002E000);
    exp_rd_ack(2, 32'h0003D000);
    rd_i = 4'b0111;
    tick(); tick();
    #2; chk("full_no_read", 64'(read), 64'd0);
    tick();
    #2; chk("full_no_read", 64'(read), 64'd0);
    tick();
    readdatavalid = 1'b1; readdata = 32'h0001F000;
    #2; chk("full_no_read", 64'(read), 64'd0);
    tick();
    readdata = 32'h0002E000;
    tick();
    readdata = 32'h0003D000;
    tick();
    readdatavalid = 1'b0; readdata = '0;
    tick(); tick();

    // Reset with two reads outstanding, then a late response.
    exp_rd_cmd(0, 32'h500);
    exp_rd_cmd(1, 32'h510);
    rd_i = 4'b0011;
    tick(); tick();
    rd_i = '0;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    readdatavalid = 1'b1; readdata = 32'hDEADBEEF;
    tick();
    readdatavalid = 1'b0; readdata = '0;
    #2;
    chk("late_proto_err", 64'(proto_err_o), 64'd1);
    chk("late_no_ack", 64'(ack_o), 64'd0);
    chk("late_dat_re", 64'(dat_re_o), 64'd0);
    tick();

    // Conflicting request on port 3.
    set_port(3, 32'h600, 16'h6000, 16'h6001);
    rd_i = 4'b1000; wr_i = 4'b1000;
    #2;
    chk("conflict_err", 64'(err_o), 64'b1000);
    chk("conflict_no_read", 64'(read), 64'd0);
    chk("conflict_no_write", 64'(write), 64'd0);
    tick();
    rd_i = '0; wr_i = '0;
    #2;
    chk("conflict_err_clear", 64'(err_o), 64'd0);
    chk("proto_err_sticky", 64'(proto_err_o), 64'd1);
    tick(); tick();

    chk("cmd_q_drained", 64'(cmd_q.size()), 64'd0);
    chk("ack_q_drained", 64'(ack_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
